// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared Alu op codes, RV32 function fields and issue FSM states
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_NOT = 4'b1000;
   localparam logic [3:0] OP_AND = 4'b1001;
   localparam logic [3:0] OP_OR  = 4'b1010;
   localparam logic [3:0] OP_XOR = 4'b1011;
   localparam logic [3:0] OP_SLL = 4'b1100;
   localparam logic [3:0] OP_SRL = 4'b1101;
   localparam logic [3:0] OP_SRA = 4'b1111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_MUL  = 3'b000;
   localparam logic [2:0] F3_DIV  = 3'b100;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_M    = 7'b0000001;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_CAPT = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0] op;
      logic       is_slt;
      logic       is_sltu;
      logic       is_shift;
      logic       is_div;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - RV32IM funct3/funct7 to Alu op code and post-processing flags
module alu_decode
   import alu_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic [6:0] i_funct7,
   input  logic       i_is_imm,
   output dec_t       o_dec
);

   always_comb begin
      o_dec    = '0;
      o_dec.op = OP_ADD;
      case (i_funct7)
         F7_BASE: begin
            case (i_funct3)
               F3_ADD:  o_dec.op = OP_ADD;
               F3_SLL:  begin o_dec.op = OP_SLL; o_dec.is_shift = 1'b1; end
               F3_SLT:  begin o_dec.op = OP_SUB; o_dec.is_slt   = 1'b1; end
               F3_SLTU: begin o_dec.op = OP_SUB; o_dec.is_sltu  = 1'b1; end
               F3_XOR:  o_dec.op = OP_XOR;
               F3_SR:   begin o_dec.op = OP_SRL; o_dec.is_shift = 1'b1; end
               F3_OR:   o_dec.op = OP_OR;
               default: o_dec.op = OP_AND;
            endcase
         end
         F7_ALT: begin
            case (i_funct3)
               F3_ADD:  o_dec.op = i_is_imm ? OP_ADD : OP_SUB;
               F3_SR:   begin o_dec.op = OP_SRA; o_dec.is_shift = 1'b1; end
               default: o_dec.illegal = 1'b1;
            endcase
         end
         F7_M: begin
            // Only register-register MUL and DIV are supported from the M extension
            if (!i_is_imm && i_funct3 == F3_MUL) begin
               o_dec.op = OP_MUL;
            end else if (!i_is_imm && i_funct3 == F3_DIV) begin
               o_dec.op     = OP_DIV;
               o_dec.is_div = 1'b1;
            end else begin
               o_dec.illegal = 1'b1;
            end
         end
         default: o_dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - execute-stage front end sequencing the registered Alu and writeback handshake
module alu_issue
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic              in_is_imm,
   input  logic [DATA_W-1:0] in_rs1,
   input  logic [DATA_W-1:0] in_rs2,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [REG_W-1:0]  in_rd,
   output logic              alu_en,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_operand0,
   output logic [DATA_W-1:0] alu_operand1,
   input  logic [DATA_W-1:0] alu_res,
   input  logic              alu_zero,
   input  logic              alu_neg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_W-1:0]  out_rd,
   output logic [DATA_W-1:0] out_data,
   output logic              out_zero,
   output logic              out_err
);

   dec_t              w_dec;
   logic [DATA_W-1:0] w_op1_raw;
   logic [DATA_W-1:0] w_op1;
   logic [DATA_W-1:0] w_capt_data;
   logic              w_skip;
   logic              w_accept;
   logic              w_lt;
   logic              w_unused_zero;

   state_t            r_state;
   logic              r_alu_en;
   logic [3:0]        r_alu_op;
   logic [DATA_W-1:0] r_alu_opd0;
   logic [DATA_W-1:0] r_alu_opd1;
   logic              r_lat_slt;
   logic              r_lat_sltu;
   logic              r_lat_s0;
   logic              r_lat_s1;
   logic [REG_W-1:0]  r_lat_rd;
   logic              r_out_valid;
   logic [REG_W-1:0]  r_out_rd;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_zero;
   logic              r_out_err;

   alu_decode u_decode (
      .i_funct3 (in_funct3),
      .i_funct7 (in_funct7),
      .i_is_imm (in_is_imm),
      .o_dec    (w_dec)
   );

   assign w_op1_raw = in_is_imm ? in_imm : in_rs2;
   assign w_op1     = w_dec.is_shift ? {{(DATA_W-5){1'b0}}, w_op1_raw[4:0]} : w_op1_raw;
   assign w_skip    = w_dec.illegal | (w_dec.is_div & (in_rs2 == '0));
   assign in_ready  = (r_state == S_IDLE) | ((r_state == S_OUT) & out_ready);
   assign w_accept  = in_valid & in_ready;

   // Zero flag is rederived from the final result, so the Alu's own flag is not needed
   assign w_unused_zero = alu_zero;

   // Set-less-than: differing signs decide directly, otherwise the SUB sign bit decides
   always_comb begin
      w_lt = alu_neg;
      if (r_lat_s0 != r_lat_s1) begin
         w_lt = r_lat_slt ? r_lat_s0 : r_lat_s1;
      end
      w_capt_data = alu_res;
      if (r_lat_slt | r_lat_sltu) begin
         w_capt_data = {{(DATA_W-1){1'b0}}, w_lt};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_alu_en    <= 1'b0;
         r_alu_op    <= '0;
         r_alu_opd0  <= '0;
         r_alu_opd1  <= '0;
         r_lat_slt   <= 1'b0;
         r_lat_sltu  <= 1'b0;
         r_lat_s0    <= 1'b0;
         r_lat_s1    <= 1'b0;
         r_lat_rd    <= '0;
         r_out_valid <= 1'b0;
         r_out_rd    <= '0;
         r_out_data  <= '0;
         r_out_zero  <= 1'b0;
         r_out_err   <= 1'b0;
      end else begin
         r_alu_en <= 1'b0;
         if (w_accept) begin
            r_lat_slt  <= w_dec.is_slt;
            r_lat_sltu <= w_dec.is_sltu;
            r_lat_s0   <= in_rs1[DATA_W-1];
            r_lat_s1   <= w_op1[DATA_W-1];
            r_lat_rd   <= in_rd;
            if (w_skip) begin
               // Illegal encodings and divide-by-zero resolve without touching the Alu
               r_state     <= S_OUT;
               r_out_valid <= 1'b1;
               r_out_rd    <= in_rd;
               r_out_err   <= w_dec.illegal;
               r_out_data  <= {DATA_W{~w_dec.illegal}};
               r_out_zero  <= w_dec.illegal;
            end else begin
               r_state     <= S_EXEC;
               r_out_valid <= 1'b0;
               r_alu_en    <= 1'b1;
               r_alu_op    <= w_dec.op;
               r_alu_opd0  <= in_rs1;
               r_alu_opd1  <= w_op1;
            end
         end else begin
            case (r_state)
               S_EXEC: r_state <= S_CAPT;
               S_CAPT: begin
                  r_state     <= S_OUT;
                  r_out_valid <= 1'b1;
                  r_out_rd    <= r_lat_rd;
                  r_out_data  <= w_capt_data;
                  r_out_zero  <= (w_capt_data == '0);
                  r_out_err   <= 1'b0;
               end
               S_OUT: begin
                  if (out_ready) begin
                     r_state     <= S_IDLE;
                     r_out_valid <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign alu_en       = r_alu_en;
   assign alu_op       = r_alu_op;
   assign alu_operand0 = r_alu_opd0;
   assign alu_operand1 = r_alu_opd1;
   assign out_valid    = r_out_valid;
   assign out_rd       = r_out_rd;
   assign out_data     = r_out_data;
   assign out_zero     = r_out_zero;
   assign out_err      = r_out_err;

endmodule
